// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan path.
// Segment codes are active-low and ordered g..a.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int nib_lsb(input int d);
    return 4 * d;
  endfunction

endpackage

// File: rtl/seg_hex_lut.sv
// Hex nibble to active-low g..a segment pattern.
module seg_hex_lut
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_LUT[nib];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment driver with frame-synchronous
// double buffering and per-slot dead time for ghost suppression.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    ready,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic [7:0]              seg_data
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = idx_bits(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [DW-1:0]         data;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] dp;
  } disp_t;

  localparam disp_t DISP_RST = '{data: '0, blank: '1, dp: '0};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pend_q, pend_d;
  disp_t                 pbuf_q, pbuf_d;
  disp_t                 act_q, act_d;
  logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
  logic [7:0]            seg_data_q, seg_data_d;

  logic                  frame_end;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_seg;
  logic [NUM_DIGITS-1:0] sel_oh;

  seg_hex_lut u_lut (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  always_comb begin
    frame_end = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // Transfer and capture are exclusive: capture needs pend_q clear.
    pend_d = pend_q;
    pbuf_d = pbuf_q;
    act_d  = act_q;
    if (frame_end && pend_q) begin
      act_d  = pbuf_q;
      pend_d = 1'b0;
    end else if (load && !pend_q) begin
      pbuf_d = '{data: data_in, blank: blank_in, dp: dp_in};
      pend_d = 1'b1;
    end

    cur_nib = act_q.data[nib_lsb(int'(idx_q)) +: 4];
    sel_oh  = '0;
    sel_oh[idx_q] = 1'b1;

    seg_sel_d  = '1;
    seg_data_d = SEG_OFF;
    if (cnt_q >= BLANK_END && !act_q.blank[idx_q]) begin
      seg_sel_d  = ~sel_oh;
      seg_data_d = {~act_q.dp[idx_q], cur_seg};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pbuf_q     <= DISP_RST;
      act_q      <= DISP_RST;
      seg_sel_q  <= '1;
      seg_data_q <= SEG_OFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pbuf_q     <= pbuf_d;
      act_q      <= act_d;
      seg_sel_q  <= seg_sel_d;
      seg_data_q <= seg_data_d;
    end
  end

  assign ready    = ~pend_q;
  assign seg_sel  = seg_sel_q;
  assign seg_data = seg_data_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 8-cycle slots, 2-cycle dead time.
module tb_seg_scan_driver;

  localparam logic [6:0] LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  dp_in = '0;
  logic        ready;
  logic [3:0]  seg_sel;
  logic [7:0]  seg_data;

  int n_chk = 0;
  int n_fail = 0;
  int ph = 0;

  logic        m_pend = 1'b0;
  logic [15:0] m_data = '0, p_data = '0;
  logic [3:0]  m_blank = 4'hF, p_blank = '0;
  logic [3:0]  m_dp = '0, p_dp = '0;

  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .data_in  (data_in),
    .blank_in (blank_in),
    .dp_in    (dp_in),
    .ready    (ready),
    .seg_sel  (seg_sel),
    .seg_data (seg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (ph %0d)", tag, got, exp, ph);
    end
  endtask

  // One clock; expected outputs come from the slot state before the edge.
  task automatic tick();
    logic [3:0] e_sel;
    logic [7:0] e_dat;
    logic [3:0] nib;
    int s_cnt, s_idx;
    e_sel = 4'hF;
    e_dat = 8'hFF;
    if (rst_n) begin
      s_cnt = ph % 8;
      s_idx = (ph / 8) % 4;
      if (s_cnt >= 2 && !m_blank[s_idx]) begin
        e_sel = ~(4'b1 << s_idx);
        nib   = m_data[s_idx*4 +: 4];
        e_dat = {~m_dp[s_idx], LUT[nib]};
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_pend = 1'b0; m_data = '0; m_blank = 4'hF; m_dp = '0; ph = 0;
    end else begin
      if ((ph % 32) == 31 && m_pend) begin
        m_data = p_data; m_blank = p_blank; m_dp = p_dp; m_pend = 1'b0;
      end else if (load && !m_pend) begin
        p_data = data_in; p_blank = blank_in; p_dp = dp_in; m_pend = 1'b1;
      end
      ph++;
    end
    #1;
    chk("seg_sel", 32'(seg_sel), 32'(e_sel));
    chk("seg_data", 32'(seg_data), 32'(e_dat));
    chk("ready", 32'(ready), 32'(!m_pend));
    chk("onehot", 32'($countones(~seg_sel) <= 1), 32'd1);
  endtask

  task automatic run_to(input int target);
    while (ph < target) tick();
  endtask

  task automatic load_once(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    load = 1'b1; data_in = d; blank_in = b; dp_in = p;
    tick();
    load = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_sel", 32'(seg_sel), 32'hF);
    chk("rst_data", 32'(seg_data), 32'hFF);
    chk("rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;

    run_to(100);
    chk("idle_sel", 32'(seg_sel), 32'hF);

    load_once(16'h1A70, 4'b0000, 4'b0010);
    chk("ld_ready_drop", 32'(ready), 32'd0);
    run_to(110);
    load_once(16'hFFFF, 4'b0000, 4'b1111);
    run_to(127);
    chk("ld_ready_wait", 32'(ready), 32'd0);
    run_to(128);
    chk("ld_ready_back", 32'(ready), 32'd1);
    run_to(136);
    chk("d0_sel", 32'(seg_sel), 32'hE);
    chk("d0_data", 32'(seg_data), 32'hC0);
    run_to(138);
    chk("d1_dead", 32'(seg_sel), 32'hF);
    run_to(139);
    chk("d1_sel", 32'(seg_sel), 32'hD);
    chk("d1_data", 32'(seg_data), 32'h78);
    run_to(148);
    chk("d2_data", 32'(seg_data), 32'h88);
    run_to(155);
    chk("d3_sel", 32'(seg_sel), 32'h7);
    chk("d3_data", 32'(seg_data), 32'hF9);

    run_to(160);
    load_once(16'h4321, 4'b0101, 4'b1000);
    run_to(196);
    chk("blk0_sel", 32'(seg_sel), 32'hF);
    run_to(203);
    chk("blk1_sel", 32'(seg_sel), 32'hD);
    chk("blk1_data", 32'(seg_data), 32'hA4);
    run_to(219);
    chk("blk3_data", 32'(seg_data), 32'h19);

    run_to(223);
    load_once(16'hBEEF, 4'b0000, 4'b0000);
    chk("fe_ready", 32'(ready), 32'd0);
    run_to(235);
    chk("fe_n1_data", 32'(seg_data), 32'hA4);
    run_to(256);
    chk("fe_ready_back", 32'(ready), 32'd1);
    run_to(267);
    chk("fe_n2_data", 32'(seg_data), 32'h86);
    run_to(283);
    chk("fe_n2_d3", 32'(seg_data), 32'h83);

    run_to(288);
    load_once(16'h8888, 4'b0000, 4'b1111);
    run_to(307);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_sel", 32'(seg_sel), 32'hF);
    chk("mrst_data", 32'(seg_data), 32'hFF);
    chk("mrst_ready", 32'(ready), 32'd1);
    run_to(80);
    chk("mrst_dark", 32'(seg_sel), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a common-anode multi-digit seven-segment display; the sink side of the hex-to-segment path.
- Accepts a packed hex word plus per-digit blank and decimal-point masks through a load/ready handshake, and double-buffers it so updates land only at frame boundaries (no tearing).
- Scans digits with a prescaled slot timer and inserts ghost-suppression dead time at the start of each slot.
- Drives active-low digit selects and active-low segments directly at the board pins.

Parameters:
- NUM_DIGITS, 6, number of digits scanned; range 2..8.
- SCAN_DIV, 50000, clock cycles per digit slot; must be greater than BLANK_CYC.
- BLANK_CYC, 500, cycles at the start of each slot with all digits off.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- load  in  1  request to load new display content; qualified by ready.
- data_in  in  4*NUM_DIGITS  hex nibbles; digit i is data_in[4i+3:4i].
- blank_in  in  NUM_DIGITS  1 = digit i dark.
- dp_in  in  NUM_DIGITS  1 = decimal point i lit.
- ready  out  1  1 = pending buffer empty, load is accepted.
- seg_sel  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all ones.
- seg_data  out  8  [7] = dp, [6:0] = g..a; all bits active-low.

Behaviour:
- Reset (rst_n low at a clk edge):
  - seg_sel = all ones; seg_data = 8'hFF; ready = 1.
  - Slot counter = 0; digit index = 0; pending flag = 0.
  - Active data = 0; active blank = all ones (display dark); active dp = 0.
  - Reset mid-load or mid-frame discards pending content.
- Slot timer:
  - cnt runs 0..SCAN_DIV-1, then wraps to 0 and increments the digit index.
  - The digit index wraps from NUM_DIGITS-1 to 0.
  - Frame end is the cycle with cnt == SCAN_DIV-1 and index == NUM_DIGITS-1.
- Handshake:
  - load && ready at a clk edge captures data_in, blank_in and dp_in into the pending buffer.
  - That same edge sets the pending flag; ready goes 0 the following cycle.
  - load while ready == 0 is ignored, with no side effects.
  - At a frame-end edge with the pending flag set: pending copies to active, the flag clears, and ready = 1 from the next cycle.
  - Load accepted on a frame-end edge: it is captured into pending only; transfer happens at the following frame end.
  - Worst-case acceptance-to-display latency: 2 frames.
- Output generation (registered, one cycle after slot state):
  - If cnt < BLANK_CYC: seg_sel = all ones and seg_data = 8'hFF.
  - Else if active blank[index]: seg_sel = all ones and seg_data = 8'hFF.
  - Else: seg_sel = ~(1 << index); seg_data[6:0] = SEG_LUT[nibble]; seg_data[7] = ~dp[index].
- SEG_LUT (g..a, active-low), 0..F:
  - 40, 79, 24, 30, 19, 12, 02, 78
  - 00, 10, 08, 03, 46, 21, 06, 0E
- Widths:
  - cnt is $clog2(SCAN_DIV) bits.
  - index is $clog2(NUM_DIGITS) bits, with explicit wrap (no reliance on power-of-two overflow).
- Invariant: seg_sel never has more than one bit low.

Decomposition:
- Package seg_pkg:
  - SEG_LUT constant array (16 x 7).
  - SEG_OFF = 8'hFF.
  - Digit index/nibble width helper functions.
- One sub-module, seg_hex_lut: combinational 4-bit to 7-bit lookup from SEG_LUT.
- Top-level contents: timer, handshake/buffer and output register.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- Reset release, no load:
  - Stimulus: run 100 cycles.
  - Required: seg_sel = 4'hF and seg_data = 8'hFF throughout; ready = 1.
- Single load:
  - Stimulus: load data_in=16'h1A70, blank_in=0, dp_in=4'b0010.
  - Required: ready drops the next cycle and returns after frame end.
  - Next frame: digit 0 shows 0x40, digit 1 shows 0x78 with dp bit 0 (seg_data 0x78), digit 2 shows 0x08, digit 3 shows 0x79.
  - Each digit is active in slot cycles 2..7 only, after the 1-cycle output lag.
- Blanking:
  - Stimulus: blank_in = 4'b0101.
  - Required: slots 0 and 2 have seg_sel = 4'hF for the full slot; slots 1 and 3 are normal.
- Back-pressure:
  - Stimulus: second load (16'hFFFF) while ready = 0.
  - Required: ignored; the display keeps the first value; only a load issued after ready returns takes effect.
- Frame-boundary collision:
  - Stimulus: load asserted exactly on the frame-end edge.
  - Required: new data appears at the start of frame N+2, not N+1.
- Reset mid-frame:
  - Stimulus: rst_n low for 1 cycle during slot 2 with a load pending.
  - Required: the next cycle has all outputs at reset values; the pending content is never displayed; ready = 1.
